// File: rtl/tft_pkg.sv
// Shared TFT definitions: RGB565 palette, pattern mode encodings, panel defaults.
// Box-axis state and its per-frame bounce step live here so other movers can reuse them.
package tft_pkg;

   localparam int H_ACT_DEF = 480;
   localparam int V_ACT_DEF = 272;

   localparam logic [15:0] COL_BLACK  = 16'h0000;
   localparam logic [15:0] COL_BLUE   = 16'h001F;
   localparam logic [15:0] COL_RED    = 16'hF800;
   localparam logic [15:0] COL_PURPLE = 16'hF81F;
   localparam logic [15:0] COL_GREEN  = 16'h07E0;
   localparam logic [15:0] COL_CYAN   = 16'h07FF;
   localparam logic [15:0] COL_YELLOW = 16'hFFE0;
   localparam logic [15:0] COL_WHITE  = 16'hFFFF;

   localparam logic [1:0] MODE_BLOCKS   = 2'd0;
   localparam logic [1:0] MODE_CHECKER  = 2'd1;
   localparam logic [1:0] MODE_GRADIENT = 2'd2;
   localparam logic [1:0] MODE_BOX      = 2'd3;

   typedef struct packed {
      logic [9:0] pos;
      logic       dn;
   } axis_t;

   function automatic logic [15:0] pal_color(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = COL_BLACK;
         3'd1:    c = COL_BLUE;
         3'd2:    c = COL_RED;
         3'd3:    c = COL_PURPLE;
         3'd4:    c = COL_GREEN;
         3'd5:    c = COL_CYAN;
         3'd6:    c = COL_YELLOW;
         default: c = COL_WHITE;
      endcase
      return c;
   endfunction

   // Clamps at the edge and reverses instead of overshooting.
   function automatic axis_t axis_step(input axis_t a, input logic [9:0] lim,
                                       input logic [9:0] step);
      axis_t n;
      n = a;
      if (!a.dn) begin
         if (({1'b0, a.pos} + {1'b0, step}) >= {1'b0, lim}) begin
            n.pos = lim;
            n.dn  = 1'b1;
         end else begin
            n.pos = a.pos + step;
         end
      end else begin
         if (a.pos <= step) begin
            n.pos = '0;
            n.dn  = 1'b0;
         end else begin
            n.pos = a.pos - step;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/tft_box_mover.sv
// Bouncing-box position: advances one step per axis on each frame start, else holds.
// Latency: new position visible the cycle after fs; no backpressure (free-running).
module tft_box_mover
   import tft_pkg::*;
#(
   parameter int STEP = 4
)(
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       fs,
   input  logic [9:0] x_lim,
   input  logic [9:0] y_lim,
   output logic [9:0] bx,
   output logic [9:0] by
);

   localparam logic [9:0] STEP_V = 10'(STEP);

   axis_t x_q, x_d;
   axis_t y_q, y_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (fs) begin
         x_d = axis_step(x_q, x_lim, STEP_V);
         y_d = axis_step(y_q, y_lim, STEP_V);
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign bx = x_q.pos;
   assign by = y_q.pos;

endmodule

// File: rtl/tft_pattern_gen.sv
// RGB565 test-pattern source (blocks/checker/gradient/bouncing box) driven by TFT_CTRL scan position.
// Latency: 2 Clk from hcount/vcount to disp_data; no backpressure, mode/animation change only on frame start.
module tft_pattern_gen
   import tft_pkg::*;
#(
   parameter int H_ACT = H_ACT_DEF,
   parameter int V_ACT = V_ACT_DEF,
   parameter int COLS  = 2,
   parameter int ROWS  = 4,
   parameter int BOX   = 32,
   parameter int STEP  = 4
)(
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic [1:0]  mode_sel,
   output logic [15:0] disp_data,
   output logic [1:0]  mode_cur,
   output logic [7:0]  frame_cnt
);

   localparam logic [9:0]  C_W   = 10'(H_ACT / COLS);
   localparam logic [9:0]  R_H   = 10'(V_ACT / ROWS);
   localparam logic [7:0]  C_MAX = 8'(COLS - 1);
   localparam logic [7:0]  R_MAX = 8'(ROWS - 1);
   localparam logic [9:0]  H_LIM = 10'(H_ACT);
   localparam logic [9:0]  V_LIM = 10'(V_ACT);
   localparam logic [9:0]  X_LIM = 10'(H_ACT - BOX);
   localparam logic [9:0]  Y_LIM = 10'(V_ACT - BOX);
   localparam logic [10:0] BOX_W = 11'(BOX);
   localparam logic [2:0]  COLS3 = 3'(COLS);

   logic        org_q, org_d;
   logic [9:0]  v_prev_q, v_prev_d;
   logic [9:0]  h1_q, h1_d, v1_q, v1_d;
   logic [7:0]  c_idx_q, c_idx_d, r_idx_q, r_idx_d;
   logic [9:0]  c_nb_q, c_nb_d, r_nb_q, r_nb_d;
   logic [1:0]  mode_q, mode_d;
   logic [7:0]  frame_q, frame_d;
   logic [15:0] disp_q, disp_d;

   logic        fs;
   logic        v_chg;
   logic [9:0]  bx, by;
   logic        in_act, in_box;
   logic [2:0]  blk_idx;

   // Edge-qualified so a counter parked at the origin fires only once.
   assign fs    = (hcount == '0) && (vcount == '0) && !org_q;
   assign v_chg = (vcount != v_prev_q);

   always_comb begin
      org_d    = (hcount == '0) && (vcount == '0);
      v_prev_d = vcount;
      h1_d     = hcount;
      v1_d     = vcount;
      mode_d   = fs ? mode_sel : mode_q;
      frame_d  = fs ? frame_q + 8'd1 : frame_q;

      // Boundary-chasing indices: the scan only ever crosses the next boundary, so no divide.
      c_idx_d = c_idx_q;
      c_nb_d  = c_nb_q;
      if (hcount == '0) begin
         c_idx_d = '0;
         c_nb_d  = C_W;
      end else if ((hcount == c_nb_q) && (c_idx_q < C_MAX)) begin
         c_idx_d = c_idx_q + 8'd1;
         c_nb_d  = c_nb_q + C_W;
      end

      r_idx_d = r_idx_q;
      r_nb_d  = r_nb_q;
      if (v_chg) begin
         if (vcount == '0) begin
            r_idx_d = '0;
            r_nb_d  = R_H;
         end else if ((vcount == r_nb_q) && (r_idx_q < R_MAX)) begin
            r_idx_d = r_idx_q + 8'd1;
            r_nb_d  = r_nb_q + R_H;
         end
      end
   end

   always_comb begin
      in_act  = (h1_q < H_LIM) && (v1_q < V_LIM);
      in_box  = (h1_q >= bx) && ({1'b0, h1_q} < ({1'b0, bx} + BOX_W)) &&
                (v1_q >= by) && ({1'b0, v1_q} < ({1'b0, by} + BOX_W));
      blk_idx = r_idx_q[2:0] * COLS3 + c_idx_q[2:0];
      disp_d  = COL_BLACK;
      if (in_act) begin
         case (mode_q)
            MODE_BLOCKS:   disp_d = pal_color(blk_idx);
            MODE_CHECKER:  disp_d = (r_idx_q[0] ^ c_idx_q[0]) ? COL_BLACK : COL_WHITE;
            MODE_GRADIENT: disp_d = {h1_q[8:4], v1_q[8:3], ~h1_q[8:4]};
            default:       disp_d = in_box ? COL_WHITE : COL_BLUE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         org_q    <= 1'b0;
         v_prev_q <= '0;
         h1_q     <= '0;
         v1_q     <= '0;
         c_idx_q  <= '0;
         r_idx_q  <= '0;
         c_nb_q   <= C_W;
         r_nb_q   <= R_H;
         mode_q   <= MODE_BLOCKS;
         frame_q  <= '0;
         disp_q   <= COL_BLACK;
      end else begin
         org_q    <= org_d;
         v_prev_q <= v_prev_d;
         h1_q     <= h1_d;
         v1_q     <= v1_d;
         c_idx_q  <= c_idx_d;
         r_idx_q  <= r_idx_d;
         c_nb_q   <= c_nb_d;
         r_nb_q   <= r_nb_d;
         mode_q   <= mode_d;
         frame_q  <= frame_d;
         disp_q   <= disp_d;
      end
   end

   tft_box_mover #(
      .STEP (STEP)
   ) u_box (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .fs    (fs),
      .x_lim (X_LIM),
      .y_lim (Y_LIM),
      .bx    (bx),
      .by    (by)
   );

   assign disp_data = disp_q;
   assign mode_cur  = mode_q;
   assign frame_cnt = frame_q;

endmodule

// File: tb/tb_tft_pattern_gen.sv
// Scoreboarded bench for tft_pattern_gen: default 2x4 grid instance plus a 4x2 grid instance on the same scan.
module tb_tft_pattern_gen;

   logic        Clk;
   logic        Rst_n;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic [1:0]  mode_sel;
   logic [15:0] disp_data, disp_data_g;
   logic [1:0]  mode_cur, mode_cur_g;
   logic [7:0]  frame_cnt, frame_cnt_g;

   typedef struct packed {
      logic        chk;
      logic [15:0] exp;
      logic [15:0] exp_g;
   } sb_t;

   sb_t   sb_q[$];
   string tag_q[$];

   int    n_chk  = 0;
   int    n_fail = 0;
   int    nfs    = 0;
   int    mode_m = 0;
   int    bx_m   = 0;
   int    by_m   = 0;
   bit    prev_org = 1'b0;

   tft_pattern_gen u_dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .hcount    (hcount),
      .vcount    (vcount),
      .mode_sel  (mode_sel),
      .disp_data (disp_data),
      .mode_cur  (mode_cur),
      .frame_cnt (frame_cnt)
   );

   tft_pattern_gen #(.COLS(4), .ROWS(2)) u_dut_g (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .hcount    (hcount),
      .vcount    (vcount),
      .mode_sel  (mode_sel),
      .disp_data (disp_data_g),
      .mode_cur  (mode_cur_g),
      .frame_cnt (frame_cnt_g)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time budget expired, checks=%0d fails=%0d", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] pal_of(input int i);
      case (i)
         0: return 16'h0000;
         1: return 16'h001F;
         2: return 16'hF800;
         3: return 16'hF81F;
         4: return 16'h07E0;
         5: return 16'h07FF;
         6: return 16'hFFE0;
         default: return 16'hFFFF;
      endcase
   endfunction

   // Reference picture: indices by plain division, box by direct containment.
   function automatic logic [15:0] ref_pix(input int mode, input int h, input int v,
                                           input int cols, input int rows,
                                           input int bx, input int by);
      logic [9:0] hh, vv;
      int c, r;
      hh = 10'(h);
      vv = 10'(v);
      if (h >= 480 || v >= 272) return 16'h0000;
      c = h / (480 / cols);
      r = v / (272 / rows);
      case (mode)
         0: return pal_of((r * cols + c) % 8);
         1: return ((r + c) % 2 == 0) ? 16'hFFFF : 16'h0000;
         2: return {hh[8:4], vv[8:3], ~hh[8:4]};
         default: return (h >= bx && h < bx + 32 && v >= by && v < by + 32) ? 16'hFFFF : 16'h001F;
      endcase
   endfunction

   // Box position after k frame starts: triangle wave of slope 4 between 0 and lim.
   function automatic int tri_pos(input int k, input int lim);
      int p;
      p = (4 * k) % (2 * lim);
      return (p <= lim) ? p : 2 * lim - p;
   endfunction

   task automatic tick(input int h, input int v, input bit chk, input string tag);
      sb_t   e, o;
      string t;
      @(negedge Clk);
      hcount = 10'(h);
      vcount = 10'(v);
      if (h == 0 && v == 0 && !prev_org) begin
         nfs++;
         mode_m = int'(mode_sel);
         bx_m   = tri_pos(nfs, 448);
         by_m   = tri_pos(nfs, 240);
      end
      prev_org = (h == 0 && v == 0);
      e.chk   = chk;
      e.exp   = ref_pix(mode_m, h, v, 2, 4, bx_m, by_m);
      e.exp_g = ref_pix(mode_m, h, v, 4, 2, bx_m, by_m);
      sb_q.push_back(e);
      tag_q.push_back(tag);
      if (sb_q.size() > 2) begin
         o = sb_q.pop_front();
         t = tag_q.pop_front();
         if (o.chk) begin
            chk_eq({t, "_2x4"}, 32'(disp_data), 32'(o.exp));
            chk_eq({t, "_4x2"}, 32'(disp_data_g), 32'(o.exp_g));
         end
      end
   endtask

   task automatic chk_ctr(input string tag);
      @(posedge Clk);
      #1;
      chk_eq({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(nfs % 256));
      chk_eq({tag, "_frame_cnt_g"}, 32'(frame_cnt_g), 32'(nfs % 256));
      chk_eq({tag, "_mode_cur"}, 32'(mode_cur), 32'(mode_m));
   endtask

   initial begin
      Rst_n    = 1'b0;
      hcount   = 10'd479;
      vcount   = 10'd271;
      mode_sel = 2'd0;
      repeat (3) @(negedge Clk);
      chk_eq("rst_disp", 32'(disp_data), 32'h0);
      chk_eq("rst_disp_g", 32'(disp_data_g), 32'h0);
      chk_eq("rst_frame_cnt", 32'(frame_cnt), 32'h0);
      chk_eq("rst_mode_cur", 32'(mode_cur), 32'h0);
      @(negedge Clk);
      Rst_n = 1'b1;

      // Frame 1: BLOCKS, full top and bottom lines, left column on every line.
      tick(0, 0, 1'b1, "blk_org");
      chk_ctr("blk_fs");
      for (int h = 1; h < 480; h++) tick(h, 0, 1'b1, "blk_l0");
      for (int v = 1; v < 271; v++) tick(0, v, 1'b1, "blk_c0");
      for (int h = 0; h < 480; h++) tick(h, 271, 1'b1, "blk_l271");

      // Frame 2: CHECKER requested mid-frame, must not show before next frame start.
      tick(0, 0, 1'b1, "mid_org");
      for (int v = 1; v < 272; v++) begin
         if (v == 100) mode_sel = 2'd1;
         tick(0, v, 1'b1, "mid_blk");
      end
      chk_ctr("mid_hold");

      // Frame 3: CHECKER active.
      tick(0, 0, 1'b1, "chk_org");
      chk_ctr("chk_fs");
      for (int h = 1; h < 480; h++) tick(h, 0, 1'b1, "chk_l0");
      for (int v = 1; v < 272; v++) tick(0, v, 1'b1, "chk_c0");

      // Frame 4: GRADIENT and blanking.
      mode_sel = 2'd2;
      tick(0, 0, 1'b1, "grad_org");
      chk_ctr("grad_fs");
      tick(255, 16, 1'b1, "grad_255_16");
      tick(100, 200, 1'b1, "grad_100_200");
      tick(500, 16, 1'b1, "grad_blank_h");
      tick(10, 300, 1'b1, "grad_blank_v");
      tick(479, 271, 1'b1, "grad_corner");

      // BOX frames through the right-edge bounce.
      mode_sel = 2'd3;
      tick(0, 0, 1'b1, "box_org");
      chk_ctr("box_fs");
      while (nfs < 116) begin
         tick(bx_m, by_m, 1'b1, "box_tl");
         if (bx_m > 0) tick(bx_m - 1, by_m, 1'b1, "box_left");
         tick(bx_m + 31, by_m + 31, 1'b1, "box_br");
         tick(bx_m + 32, by_m + 31, 1'b1, "box_right");
         tick(bx_m + 15, by_m + 32, 1'b1, "box_below");
         tick(0, 0, 1'b1, "box_org");
      end

      // 256 frame starts wrap the counter back to the same value.
      chk_ctr("wrap_pre");
      for (int i = 0; i < 256; i++) begin
         tick(1, 0, 1'b0, "wrap");
         tick(0, 0, 1'b0, "wrap");
      end
      chk_ctr("wrap_post");

      // Counter stalled at origin: exactly one frame start.
      tick(7, 7, 1'b0, "stall_pre");
      tick(0, 0, 1'b1, "stall0");
      tick(0, 0, 1'b1, "stall1");
      tick(0, 0, 1'b1, "stall2");
      chk_ctr("stall");

      tick(3, 3, 1'b0, "flush");
      tick(3, 3, 1'b0, "flush");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
